// File: rtl/usb_serial_cpu_if_pkg.sv
// Shared constants for the USB serial CPU bridge: register map and bit positions.
package usb_serial_cpu_if_pkg;

    localparam logic [2:0] REG_DATA   = 3'd0;
    localparam logic [2:0] REG_STATUS = 3'd1;
    localparam logic [2:0] REG_CTRL   = 3'd2;
    localparam logic [2:0] REG_RXCNT  = 3'd3;
    localparam logic [2:0] REG_TXFREE = 3'd4;

    localparam int unsigned STAT_RX_NE    = 0;
    localparam int unsigned STAT_TX_NF    = 1;
    localparam int unsigned STAT_TX_EMPTY = 2;
    localparam int unsigned STAT_RX_OVF   = 3;
    localparam int unsigned STAT_TX_OVF   = 4;

    localparam int unsigned CTRL_RX_IE = 0;
    localparam int unsigned CTRL_TX_IE = 1;

endpackage

// File: rtl/sync_fifo.sv
// Byte-wide first-word-fall-through FIFO; push/pop are qualified internally so a push
// into a full FIFO succeeds when a pop happens in the same cycle.
module sync_fifo #(
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [7:0]            wr_data,
    input  logic                  rd_en,
    output logic [7:0]            rd_data,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned CW    = DEPTH_LOG2 + 1;

    logic [7:0]            mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]         count_q, count_d;
    logic                  do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign do_pop  = rd_en & ~empty;
    assign do_push = wr_en & (~full | do_pop);
    assign rd_data = mem_q[rd_ptr_q];
    assign count   = count_q;

    always_comb begin
        count_d = count_q;
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + DEPTH_LOG2'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + DEPTH_LOG2'(1);
            count_q <= count_d;
        end
    end

    // Storage needs no reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/usb_serial_cpu_if.sv
// 6502-side register bridge to the USB UART byte pipes: TX/RX FIFOs, status/control
// registers, sticky overflow flags and a level interrupt.
module usb_serial_cpu_if
    import usb_serial_cpu_if_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cs,
    input  logic       we,
    input  logic [2:0] addr,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       rx_ready,
    output logic       irq
);

    localparam int unsigned CW = DEPTH_LOG2 + 1;

    logic          rd_acc, wr_acc;
    logic          tx_push, tx_pop, rx_pop;
    logic          tx_full, tx_empty, rx_full, rx_empty;
    logic [CW-1:0] tx_count, rx_count, tx_free;
    logic [7:0]    rx_head;
    logic [7:0]    status, rd_val;
    logic [7:0]    dout_q;
    logic [1:0]    ctrl_q;
    logic          rx_ovf_q, rx_ovf_d, tx_ovf_q, tx_ovf_d;
    logic          irq_q;

    assign rd_acc  = cs & ~we;
    assign wr_acc  = cs & we;
    assign tx_push = wr_acc & (addr == REG_DATA);
    assign rx_pop  = rd_acc & (addr == REG_DATA);

    assign tx_valid = ~tx_empty;
    assign tx_pop   = tx_valid & tx_ready;
    // A CPU pop frees a slot this cycle, so a full RX FIFO can still take a byte.
    assign rx_ready = ~rx_full | rx_pop;

    sync_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_tx_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (tx_push),
        .wr_data (din),
        .rd_en   (tx_ready),
        .rd_data (tx_data),
        .full    (tx_full),
        .empty   (tx_empty),
        .count   (tx_count)
    );

    sync_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_rx_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (rx_valid),
        .wr_data (rx_data),
        .rd_en   (rx_pop),
        .rd_data (rx_head),
        .full    (rx_full),
        .empty   (rx_empty),
        .count   (rx_count)
    );

    assign tx_free = CW'(1 << DEPTH_LOG2) - tx_count;

    // Set events win over a same-cycle write-1-to-clear.
    always_comb begin
        rx_ovf_d = rx_ovf_q;
        tx_ovf_d = tx_ovf_q;
        if (wr_acc && addr == REG_STATUS) begin
            if (din[STAT_RX_OVF]) rx_ovf_d = 1'b0;
            if (din[STAT_TX_OVF]) tx_ovf_d = 1'b0;
        end
        if (rx_valid && !rx_ready)          rx_ovf_d = 1'b1;
        if (tx_push && tx_full && !tx_pop)  tx_ovf_d = 1'b1;
    end

    always_comb begin
        status                = '0;
        status[STAT_RX_NE]    = ~rx_empty;
        status[STAT_TX_NF]    = ~tx_full;
        status[STAT_TX_EMPTY] = tx_empty;
        status[STAT_RX_OVF]   = rx_ovf_q;
        status[STAT_TX_OVF]   = tx_ovf_q;
    end

    always_comb begin
        rd_val = 8'h00;
        case (addr)
            REG_DATA:   rd_val = rx_empty ? 8'h00 : rx_head;
            REG_STATUS: rd_val = status;
            REG_CTRL:   rd_val = {6'b0, ctrl_q};
            REG_RXCNT:  rd_val = 8'(rx_count);
            REG_TXFREE: rd_val = 8'(tx_free);
            default:    rd_val = 8'h00;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dout_q   <= 8'h00;
            ctrl_q   <= 2'b00;
            rx_ovf_q <= 1'b0;
            tx_ovf_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            if (rd_acc) dout_q <= rd_val;
            if (wr_acc && addr == REG_CTRL) ctrl_q <= din[1:0];
            rx_ovf_q <= rx_ovf_d;
            tx_ovf_q <= tx_ovf_d;
            irq_q    <= (ctrl_q[CTRL_RX_IE] & ~rx_empty) | (ctrl_q[CTRL_TX_IE] & tx_empty);
        end
    end

    assign dout = dout_q;
    assign irq  = irq_q;

endmodule

// File: tb/tb_usb_serial_cpu_if.sv
// Scoreboard bench for usb_serial_cpu_if: queues of expected TX and RX bytes are filled as
// stimulus is driven and drained as the DUT emits bytes or the CPU reads them.
module tb_usb_serial_cpu_if;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cs = 1'b0, we = 1'b0;
    logic [2:0] addr = '0;
    logic [7:0] din = '0;
    logic [7:0] dout;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready = 1'b0;
    logic [7:0] rx_data = '0;
    logic       rx_valid = 1'b0;
    logic       rx_ready;
    logic       irq;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] tx_q [$];
    logic [7:0] rx_q [$];

    usb_serial_cpu_if #(.DEPTH_LOG2(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .cs       (cs),
        .we       (we),
        .addr     (addr),
        .din      (din),
        .dout     (dout),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Handshakes are observed mid-cycle; they complete at the following rising edge.
    always @(negedge clk) begin
        if (rst) begin
            if (tx_valid && tx_ready) begin
                if (tx_q.size() == 0) check_eq("tx_spurious", 32'(tx_valid), 32'd0);
                else                  check_eq("tx_data", 32'(tx_data), 32'(tx_q.pop_front()));
            end
            if (rx_valid && rx_ready) rx_q.push_back(rx_data);
        end
    end

    // All bus tasks start and end 1 ns after a rising edge.
    task automatic bus_write(input logic [2:0] a, input logic [7:0] d);
        if (a == 3'd0 && (tx_q.size() < 16 || (tx_ready && tx_q.size() > 0)))
            tx_q.push_back(d);
        cs = 1'b1; we = 1'b1; addr = a; din = d;
        @(posedge clk); #1;
        cs = 1'b0; we = 1'b0;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [7:0] d);
        cs = 1'b1; we = 1'b0; addr = a;
        @(posedge clk); #1;
        cs = 1'b0;
        d = dout;
    endtask

    task automatic read_check(input string tag, input logic [2:0] a, input logic [7:0] exp);
        logic [7:0] d;
        bus_read(a, d);
        check_eq(tag, 32'(d), 32'(exp));
    endtask

    task automatic read_data(input string tag);
        logic [7:0] exp;
        logic [7:0] d;
        exp = (rx_q.size() > 0) ? rx_q.pop_front() : 8'h00;
        bus_read(3'd0, d);
        check_eq(tag, 32'(d), 32'(exp));
    endtask

    task automatic core_send(input logic [7:0] b);
        logic ok;
        ok = 1'b0;
        rx_data = b; rx_valid = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            ok = rx_ready;
            @(posedge clk); #1;
        end
        rx_valid = 1'b0;
        if (!ok) check_eq("rx_handshake_timeout", 32'(rx_ready), 32'd1);
    endtask

    task automatic wait_tx_drain(input string tag);
        for (int i = 0; i < 40 && tx_q.size() != 0; i++) begin
            @(posedge clk); #1;
        end
        check_eq(tag, 32'(tx_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_tx_valid", 32'(tx_valid), 32'd0);
        check_eq("rst_irq", 32'(irq), 32'd0);
        check_eq("rst_dout", 32'(dout), 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;

        // Async reset mid-transfer with three bytes stalled.
        bus_write(3'd0, 8'h01);
        bus_write(3'd0, 8'h02);
        bus_write(3'd0, 8'h03);
        check_eq("pre_rst_tx_valid", 32'(tx_valid), 32'd1);
        #2 rst = 1'b0;
        #1;
        check_eq("async_rst_tx_valid", 32'(tx_valid), 32'd0);
        tx_q.delete();
        @(posedge clk); #1;
        rst = 1'b1;
        check_eq("rx_ready_after_rst", 32'(rx_ready), 32'd1);
        read_check("status_after_rst", 3'd1, 8'h06);
        read_check("rxcnt_after_rst", 3'd3, 8'h00);
        check_eq("irq_after_rst", 32'(irq), 32'd0);

        // TX stall then ordered drain.
        bus_write(3'd0, 8'h41);
        bus_write(3'd0, 8'h42);
        bus_write(3'd0, 8'h43);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("tx_stall_data", 32'(tx_data), 32'h41);
            check_eq("tx_stall_valid", 32'(tx_valid), 32'd1);
        end
        @(posedge clk); #1;
        tx_ready = 1'b1;
        wait_tx_drain("tx_drain_abc");
        tx_ready = 1'b0;
        read_check("txfree_16", 3'd4, 8'd16);

        // TX overflow: 17 writes into a stalled FIFO.
        for (int i = 0; i < 17; i++) bus_write(3'd0, 8'(8'h60 + i));
        read_check("txfree_0", 3'd4, 8'd0);
        read_check("status_tx_ovf", 3'd1, 8'h10);
        bus_write(3'd1, 8'h10);
        read_check("status_tx_ovf_clr", 3'd1, 8'h00);
        tx_ready = 1'b1;
        wait_tx_drain("tx_drain_16");
        repeat (3) @(posedge clk);
        #1;
        check_eq("tx_idle_after_drain", 32'(tx_valid), 32'd0);
        tx_ready = 1'b0;

        // RX basic path including read from empty.
        core_send(8'h55);
        core_send(8'hAA);
        read_check("rxcnt_2", 3'd3, 8'd2);
        read_data("rx_data_55");
        read_data("rx_data_aa");
        read_data("rx_data_empty");
        read_check("status_rx_empty", 3'd1, 8'h06);

        // RX full, backpressure, overflow flag and simultaneous pop/push.
        for (int i = 0; i < 16; i++) core_send(8'(8'h80 + i));
        read_check("rxcnt_16", 3'd3, 8'd16);
        rx_data = 8'hEE; rx_valid = 1'b1;
        @(posedge clk); #1;
        check_eq("rx_ready_full", 32'(rx_ready), 32'd0);
        @(posedge clk); #1;
        read_check("status_rx_ovf", 3'd1, 8'h0F);
        read_data("rx_pop_while_full");
        rx_valid = 1'b0;
        read_check("rxcnt_still_16", 3'd3, 8'd16);
        bus_write(3'd1, 8'h08);
        read_check("status_rx_ovf_clr", 3'd1, 8'h07);
        for (int i = 0; i < 16; i++) read_data("rx_drain");
        read_check("status_rx_drained", 3'd1, 8'h06);

        // Interrupts.
        bus_write(3'd2, 8'h01);
        @(posedge clk); #1;
        check_eq("irq_rx_ie_empty", 32'(irq), 32'd0);
        core_send(8'h77);
        check_eq("irq_lag", 32'(irq), 32'd0);
        @(posedge clk); #1;
        check_eq("irq_rx", 32'(irq), 32'd1);
        read_data("rx_data_77");
        @(posedge clk); #1;
        check_eq("irq_rx_cleared", 32'(irq), 32'd0);
        bus_write(3'd2, 8'h02);
        @(posedge clk); #1;
        check_eq("irq_tx_empty", 32'(irq), 32'd1);
        read_check("ctrl_readback", 3'd2, 8'h02);
        read_check("reg5_zero", 3'd5, 8'h00);
        bus_write(3'd6, 8'hFF);
        read_check("ctrl_after_reg6_write", 3'd2, 8'h02);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
